// File: rtl/gfx_pkg.sv
// Shared types and constants for the point transform feeder.
// Coordinate widths are fixed here so the point struct and the engine agree.
package gfx_pkg;

  localparam int POINT_WIDTH    = 16;
  localparam int SUBPIXEL_WIDTH = 16;
  localparam int COORD_WIDTH    = POINT_WIDTH + SUBPIXEL_WIDTH;
  localparam int POINT_ID_LAST  = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT_ACK,
    ST_TRI_OUT
  } feeder_state_e;

  typedef struct packed {
    logic signed [COORD_WIDTH-1:0] x;
    logic signed [COORD_WIDTH-1:0] y;
    logic signed [COORD_WIDTH-1:0] z;
    logic                          xform;
  } gfx_point_t;

endpackage

// File: rtl/gfx_point_fifo.sv
// Synchronous FIFO of points with a synchronous flush; head entry is
// presented combinationally on data_o whenever the FIFO is non-empty.
module gfx_point_fifo
  import gfx_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       flush_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  gfx_point_t data_i,
  output gfx_point_t data_o,
  output logic       full_o,
  output logic       empty_o
);

  localparam int AW = $clog2(DEPTH);

  gfx_point_t      r_mem [DEPTH];
  logic [AW-1:0]   r_wr_ptr;
  logic [AW-1:0]   r_rd_ptr;
  logic [AW:0]     r_count;
  logic            w_push;
  logic            w_pop;

  assign full_o  = (r_count == (AW+1)'(DEPTH));
  assign empty_o = (r_count == '0);
  assign w_push  = push_i && !full_o;
  assign w_pop   = pop_i && !empty_o;
  assign data_o  = r_mem[r_rd_ptr];

  // NOTE: storage is deliberately not reset; the pointers alone define which entries are valid.
  always_ff @(posedge clk_i) begin
    if (w_push) r_mem[r_wr_ptr] <= data_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush_i) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/gfx_transform_feeder.sv
// Feeds buffered points one at a time to the transform engine and signals
// the rasterizer once three points (one triangle) have been acknowledged.
module gfx_transform_feeder
  import gfx_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   pt_valid_i,
  output logic                   pt_ready_o,
  input  logic [COORD_WIDTH-1:0] pt_x_i,
  input  logic [COORD_WIDTH-1:0] pt_y_i,
  input  logic [COORD_WIDTH-1:0] pt_z_i,
  input  logic                   pt_xform_i,
  input  logic                   flush_i,
  output logic [COORD_WIDTH-1:0] x_o,
  output logic [COORD_WIDTH-1:0] y_o,
  output logic [COORD_WIDTH-1:0] z_o,
  output logic [1:0]             point_id_o,
  output logic                   transform_o,
  output logic                   forward_o,
  input  logic                   ack_i,
  output logic                   tri_valid_o,
  input  logic                   tri_ready_i,
  output logic                   busy_o,
  output logic                   timeout_o
);

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  feeder_state_e    r_state;
  feeder_state_e    w_next_state;
  gfx_point_t       r_hold;
  logic [1:0]       r_idx;
  logic [CNT_W-1:0] r_wait_cnt;
  logic             r_timeout;

  gfx_point_t       w_in_point;
  gfx_point_t       w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_push;
  logic             w_pop;
  logic             w_last_point;
  logic             w_timeout_hit;

  assign w_in_point    = '{x: pt_x_i, y: pt_y_i, z: pt_z_i, xform: pt_xform_i};
  assign pt_ready_o    = !w_full && !flush_i;
  assign w_push        = pt_valid_i && pt_ready_o;
  assign w_pop         = (r_state == ST_IDLE) && !w_empty && !flush_i;
  assign w_last_point  = (r_idx == 2'(POINT_ID_LAST));
  assign w_timeout_hit = (r_state == ST_WAIT_ACK) && !ack_i &&
                         (r_wait_cnt == CNT_W'(TIMEOUT - 1));

  gfx_point_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .flush_i (flush_i),
    .push_i  (w_push),
    .pop_i   (w_pop),
    .data_i  (w_in_point),
    .data_o  (w_head),
    .full_o  (w_full),
    .empty_o (w_empty)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) r_state <= ST_IDLE;
    else         r_state <= w_next_state;
  end

  // NOTE: next state gets its default first so no path leaves it unassigned (no latch).
  always_comb begin
    w_next_state = r_state;
    if (flush_i) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:     if (!w_empty) w_next_state = ST_ISSUE;
        ST_ISSUE:    w_next_state = ST_WAIT_ACK;
        ST_WAIT_ACK: begin
          if (ack_i)              w_next_state = w_last_point ? ST_TRI_OUT : ST_IDLE;
          else if (w_timeout_hit) w_next_state = ST_IDLE;
        end
        ST_TRI_OUT:  if (tri_ready_i) w_next_state = ST_IDLE;
        default:     w_next_state = ST_IDLE;
      endcase
    end
  end

  // Datapath: hold regs, point index, ack watchdog and sticky timeout flag.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_hold     <= '0;
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else if (flush_i) begin
      r_idx      <= '0;
      r_wait_cnt <= '0;
      r_timeout  <= 1'b0;
    end else begin
      if (w_pop) r_hold <= w_head;
      case (r_state)
        ST_ISSUE: r_wait_cnt <= '0;
        ST_WAIT_ACK: begin
          if (ack_i) begin
            r_idx <= w_last_point ? 2'd0 : r_idx + 2'd1;
          end else if (w_timeout_hit) begin
            r_timeout <= 1'b1;
            r_idx     <= '0;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign x_o         = r_hold.x;
  assign y_o         = r_hold.y;
  assign z_o         = r_hold.z;
  assign point_id_o  = r_idx;
  assign transform_o = (r_state == ST_ISSUE) && r_hold.xform;
  assign forward_o   = (r_state == ST_ISSUE) && !r_hold.xform;
  assign tri_valid_o = (r_state == ST_TRI_OUT);
  assign busy_o      = (r_state != ST_IDLE) || !w_empty;
  assign timeout_o   = r_timeout;

endmodule

// File: doc/gfx_transform_feeder.md
Name: gfx_transform_feeder

Overview:
- Initiator side of the point transform engine handshake.
- Takes buffered points from the command/register front end and presents them one at a time to the transform engine. Each point gets a one-cycle transform or forward request. The feeder holds the point stable until the engine's ack, then advances point index 0→1→2.
- Once all three points are acked, it raises a triangle-ready handshake toward the rasterizer, which then reads p0..p2 from the engine.

Parameters:
- POINT_WIDTH, 16, integer bits of coordinates (matches the engine).
- SUBPIXEL_WIDTH, 16, fractional bits of coordinates.
- FIFO_DEPTH, 4, input point buffer entries (power of two, ≥2).
- TIMEOUT, 15, maximum cycles to wait for ack_i before aborting (≥3).

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- pt_valid_i  in  1  upstream point valid.
- pt_ready_o  out  1  feeder can accept a point.
- pt_x_i  in  PW+SW  signed fixed-point x.
- pt_y_i  in  PW+SW  signed fixed-point y.
- pt_z_i  in  PW+SW  signed fixed-point z.
- pt_xform_i  in  1  1 = transform, 0 = forward.
- flush_i  in  1  synchronous abort/clear.
- x_o, y_o, z_o  out  PW+SW each  point to the engine; held stable from request until ack.
- point_id_o  out  2  current point index 0..2.
- transform_o  out  1  one-cycle transform request.
- forward_o  out  1  one-cycle forward request.
- ack_i  in  1  engine completion pulse.
- tri_valid_o  out  1  p0..p2 in the engine are complete.
- tri_ready_i  in  1  rasterizer has taken the triangle.
- busy_o  out  1  state ≠ IDLE or FIFO non-empty.
- timeout_o  out  1  sticky; ack not received within TIMEOUT cycles.

Behaviour:
- Reset (rst_ni low, async): state=IDLE, FIFO empty, idx=0, hold regs=0. All outputs 0 except pt_ready_o=1.
- pt_ready_o = !fifo_full && !flush_i. A push occurs when pt_valid_i && pt_ready_o. There is no bypass: a pushed point is poppable the following cycle at earliest.
- FSM states: IDLE, ISSUE, WAIT_ACK, TRI_OUT.
- IDLE:
  - FIFO non-empty → pop head into hold regs (x, y, z, xform) → ISSUE.
  - Otherwise stay.
- ISSUE (exactly 1 cycle):
  - transform_o = hold_xform; forward_o = !hold_xform. Never both high.
  - Clear wait counter → WAIT_ACK.
- WAIT_ACK:
  - ack_i with idx<2 → idx+1 → IDLE.
  - ack_i with idx=2 → idx=0 → TRI_OUT.
  - No ack_i: counter increments. On the TIMEOUT-th consecutive cycle without ack: set timeout_o, idx=0 (triangle abandoned) → IDLE.
- TRI_OUT:
  - tri_valid_o=1 until tri_ready_i is sampled high → IDLE.
  - No new request is issued while in TRI_OUT, so engine outputs stay stable.
- Output timing:
  - x_o/y_o/z_o/point_id_o are driven from hold regs and idx, registered, and stable ISSUE through WAIT_ACK.
  - transform_o, forward_o and tri_valid_o are Moore decodes of the registered state.
- ack_i is ignored in every state except WAIT_ACK; spurious or late acks have no effect.
- Latency:
  - Engine acks 2 cycles after the request cycle.
  - Push at cycle 0 → ISSUE at cycle 2 → ack at cycle 4 → IDLE at cycle 5. Steady state is 4 cycles per point.
- flush_i (synchronous, highest priority, any state): FIFO emptied, idx=0, timeout_o cleared → IDLE. Any push attempted in that cycle is dropped (ready is low).
  - Engine ack from an in-flight request arrives before the next ISSUE and is ignored.
- FIFO full: pt_ready_o is low; the upstream holds. A pop and a push in the same cycle are both honoured when not full.
- Async reset mid-operation: immediate return to the reset values above. The engine is reset by the same system reset.

Decomposition:
- gfx_pkg holds:
  - the feeder state typedef (feeder_state_e);
  - the point struct gfx_point_t {x, y, z, xform}, sized from POINT_WIDTH/SUBPIXEL_WIDTH;
  - localparam POINT_ID_LAST = 2.
- One sub-module, gfx_point_fifo: a parameterised synchronous FIFO of gfx_point_t with push/pop/full/empty/flush.

Test Plan:
- Reset, then push three transform points (1.0,2.0,0), (3.0,4.0,0), (5.0,6.0,0) with the engine model acking 2 cycles after each request.
  - transform_o pulses 1 cycle each with point_id_o 0,1,2.
  - First pulse occurs 2 cycles after the first push.
  - tri_valid_o rises the cycle after the third ack and holds 3 cycles until tri_ready_i is raised.
- Forward-only points (x=0x00010000):
  - forward_o pulses, transform_o stays 0.
  - x_o is stable from ISSUE until ack.
- Push 6 points back-to-back with FIFO_DEPTH=4:
  - pt_ready_o drops after 4 stored.
  - No point is lost or reordered.
  - Two triangles are signalled in order.
- Engine model never acks:
  - timeout_o goes high 15 cycles after entering WAIT_ACK and stays high.
  - idx returns to 0.
  - The next point issues with point_id_o=0.
- flush_i asserted during WAIT_ACK of point 1, with the engine ack arriving the cycle after flush:
  - The ack is ignored.
  - FIFO is empty and idx=0.
  - A subsequent push issues with point_id_o=0.
- rst_ni dropped mid-TRI_OUT (asynchronously, between clock edges):
  - tri_valid_o and busy_o go low immediately.
  - pt_ready_o=1.
